mpm_port_scheduler: RTL and testbench

MPM_PORT_SCHEDULER -- requirements
Module: mpm_port_scheduler

---
 rtl/mpm_pkg.sv | 18 +
 rtl/mpm_port_scheduler_if.sv | 37 +++
 rtl/mpm_read_tracker.sv | 56 +++++
 rtl/mpm_port_scheduler.sv | 112 +++++++++++
 tb/tb_mpm_port_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mpm_pkg.sv
// Shared types for the multi-port memory scheduler.
//   ID_W     : width of the requester id carried with an in-flight read
//   PORT_W   : width of the memory port index carried with an in-flight read
//   rd_rec_t : one in-flight read record {valid, requester id, port index}
// The widths are fixed upper bounds (up to 16 requesters / 16 ports); users
// slice them down to the configured size.
package mpm_pkg;

  localparam int ID_W   = 4;
  localparam int PORT_W = 4;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [PORT_W-1:0] port;
  } rd_rec_t;

endpackage

// File: rtl/mpm_port_scheduler_if.sv
// Bundle of requester-side and memory-side signals of the port scheduler.
//   req_*/rsp_* : per-requester request handshake and read return
//   mem_*       : per-port connection to an external multi-port memory
// Modports: slave = the scheduler, master = clients plus memory model.
interface mpm_port_scheduler_if
  import mpm_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int PORTS      = 2,
  parameter int REQUESTERS = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [REQUESTERS-1:0]            req_valid;
  logic [REQUESTERS-1:0]            req_ready;
  logic [REQUESTERS-1:0]            req_we;
  logic [REQUESTERS-1:0][AW-1:0]    req_addr;
  logic [REQUESTERS-1:0][WIDTH-1:0] req_d;
  logic [REQUESTERS-1:0]            rsp_valid;
  logic [REQUESTERS-1:0][WIDTH-1:0] rsp_q;
  logic [PORTS-1:0][AW-1:0]         mem_addr;
  logic [PORTS-1:0]                 mem_en;
  logic [PORTS-1:0][WIDTH-1:0]      mem_d;
  logic [PORTS-1:0][WIDTH-1:0]      mem_q;

  modport slave (
    input  req_valid, req_we, req_addr, req_d, mem_q,
    output req_ready, rsp_valid, rsp_q, mem_addr, mem_en, mem_d
  );

  modport master (
    output req_valid, req_we, req_addr, req_d, mem_q,
    input  req_ready, rsp_valid, rsp_q, mem_addr, mem_en, mem_d
  );

endinterface

// File: rtl/mpm_read_tracker.sv
// Read-return pipeline: carries granted reads for READ_LATENCY cycles and,
// at the exit, routes mem_q of the recorded port to the recorded requester.
//   clk, rst_n : clock, async active-low reset (drops every record in flight)
//   rec_in     : per-port read records entering this cycle
//   mem_q      : per-port read data from the memory
//   rsp_valid  : one-cycle pulse per requester whose read completes
//   rsp_q      : read data, zero for requesters without a response
module mpm_read_tracker
  import mpm_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int PORTS        = 2,
  parameter int REQUESTERS   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  rd_rec_t [PORTS-1:0]              rec_in,
  input  logic    [PORTS-1:0][WIDTH-1:0]   mem_q,
  output logic    [REQUESTERS-1:0]         rsp_valid,
  output logic    [REQUESTERS-1:0][WIDTH-1:0] rsp_q
);
  localparam int IW = $clog2(REQUESTERS);
  localparam int PW = $clog2(PORTS);

  rd_rec_t [PORTS-1:0] pipe_p [READ_LATENCY];
  rd_rec_t [PORTS-1:0] exit_rec;
  logic                unused_rec;

  // stage boundary: record shift, one stage per cycle of memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < READ_LATENCY; s++) pipe_p[s] <= '0;
    end else begin
      pipe_p[0] <= rec_in;
      for (int s = 1; s < READ_LATENCY; s++) pipe_p[s] <= pipe_p[s-1];
    end
  end

  assign exit_rec   = pipe_p[READ_LATENCY-1];
  // Upper id/port bits beyond the configured size are always zero.
  assign unused_rec = ^exit_rec;

  // stage boundary: exit, data arrives from the memory in this same cycle
  always_comb begin
    rsp_valid = '0;
    rsp_q     = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (exit_rec[k].valid) begin
        rsp_valid[exit_rec[k].id[IW-1:0]] = 1'b1;
        rsp_q[exit_rec[k].id[IW-1:0]]     = mem_q[exit_rec[k].port[PW-1:0]];
      end
    end
  end

endmodule

// File: rtl/mpm_port_scheduler.sv
// Round-robin scheduler of REQUESTERS clients onto PORTS memory ports.
//   clk, rst_n : clock, async active-low reset
//   bus        : requester handshake (req_*/rsp_*) and memory port (mem_*)
// Up to PORTS requests are granted per cycle, scanning from rr_ptr; the k-th
// grant drives port k combinationally. Same-address hazards inside one cycle
// (anything against a granted write, a write against a granted read) defer
// the later candidate. Reads return through mpm_read_tracker.
module mpm_port_scheduler
  import mpm_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int PORTS        = 2,
  parameter int REQUESTERS   = 4,
  parameter int READ_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mpm_port_scheduler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(REQUESTERS);

  logic [IW-1:0]               rr_ptr;
  logic [IW-1:0]               next_ptr;
  logic                        armed;
  logic                        any_grant;
  logic [REQUESTERS-1:0]       ready;
  logic [PORTS-1:0]            g_we;
  logic [PORTS-1:0][AW-1:0]    g_addr;
  logic [PORTS-1:0][WIDTH-1:0] g_d;
  rd_rec_t [PORTS-1:0]         new_rd;
  int                          n_gr;
  int                          scan_int;
  logic [IW-1:0]               scan_idx;
  logic                        conflict;

  // armed stays low for the first cycle after reset release so that no
  // request is granted until the first clock edge has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      armed <= 1'b1;
      if (any_grant) rr_ptr <= next_ptr;
    end
  end

  always_comb begin
    ready     = '0;
    g_we      = '0;
    g_addr    = '0;
    g_d       = '0;
    new_rd    = '0;
    any_grant = 1'b0;
    next_ptr  = rr_ptr;
    n_gr      = 0;
    scan_int  = 0;
    scan_idx  = '0;
    conflict  = 1'b0;
    if (armed) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        scan_int = int'(rr_ptr) + i;
        if (scan_int >= REQUESTERS) scan_int = scan_int - REQUESTERS;
        scan_idx = IW'(scan_int);
        conflict = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
          if (k < n_gr && g_addr[k] == bus.req_addr[scan_idx] &&
              (g_we[k] || bus.req_we[scan_idx]))
            conflict = 1'b1;
        end
        if (bus.req_valid[scan_idx] && n_gr < PORTS && !conflict) begin
          ready[scan_idx] = 1'b1;
          for (int k = 0; k < PORTS; k++) begin
            if (k == n_gr) begin
              g_we[k]   = bus.req_we[scan_idx];
              g_addr[k] = bus.req_addr[scan_idx];
              g_d[k]    = bus.req_we[scan_idx] ? bus.req_d[scan_idx] : '0;
              new_rd[k] = '{valid: !bus.req_we[scan_idx],
                            id:    ID_W'(scan_idx),
                            port:  PORT_W'(k)};
            end
          end
          n_gr      = n_gr + 1;
          any_grant = 1'b1;
          next_ptr  = (scan_int == REQUESTERS - 1) ? '0 : IW'(scan_int + 1);
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_en    = g_we;
  assign bus.mem_addr  = g_addr;
  assign bus.mem_d     = g_d;

  mpm_read_tracker #(
    .WIDTH        (WIDTH),
    .PORTS        (PORTS),
    .REQUESTERS   (REQUESTERS),
    .READ_LATENCY (READ_LATENCY)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec_in    (new_rd),
    .mem_q     (bus.mem_q),
    .rsp_valid (bus.rsp_valid),
    .rsp_q     (bus.rsp_q)
  );

endmodule

// File: tb/tb_mpm_port_scheduler.sv
// Directed bench for mpm_port_scheduler: one instance with READ_LATENCY=1
// (arbitration, hazards, ordering, fairness) and one with READ_LATENCY=3
// (reset while a read is in flight). Unwritten memory words read as
// 0x1000 + address.
module tb_mpm_port_scheduler;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   gcnt [4];
  int   wt [4];
  int   maxwt;

  always #5 clk = ~clk;

  mpm_port_scheduler_if ifa ();
  mpm_port_scheduler_if ifb ();

  mpm_port_scheduler #(.READ_LATENCY(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ifa.slave)
  );

  mpm_port_scheduler #(.READ_LATENCY(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb.slave)
  );

  // Memory for instance A: one-cycle read, write on mem_en.
  logic [31:0]  mem_a [256];
  logic [255:0] wr_a;
  always @(posedge clk) begin
    if (!rst_n_a) wr_a <= '0;
    for (int k = 0; k < 2; k++) begin
      ifa.mem_q[k] <= wr_a[ifa.mem_addr[k]] ? mem_a[ifa.mem_addr[k]]
                                            : 32'h1000 + 32'(ifa.mem_addr[k]);
      if (rst_n_a && ifa.mem_en[k]) begin
        mem_a[ifa.mem_addr[k]] <= ifa.mem_d[k];
        wr_a[ifa.mem_addr[k]]  <= 1'b1;
      end
    end
  end

  // Memory for instance B: read-only, three-cycle read.
  logic [1:0][31:0] b_q1, b_q2;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      b_q1[k]      <= 32'h1000 + 32'(ifb.mem_addr[k]);
      b_q2[k]      <= b_q1[k];
      ifb.mem_q[k] <= b_q2[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_b_quiet(input string tag);
    check({tag, "_ready"}, 32'(ifb.req_ready), 32'h0);
    check({tag, "_mem_en"}, 32'(ifb.mem_en), 32'h0);
    check({tag, "_mem_addr"}, 32'(ifb.mem_addr), 32'h0);
    check({tag, "_mem_d"}, ifb.mem_d[0] | ifb.mem_d[1], 32'h0);
    check({tag, "_rsp_valid"}, 32'(ifb.rsp_valid), 32'h0);
    check({tag, "_rsp_q"}, ifb.rsp_q[0] | ifb.rsp_q[1] | ifb.rsp_q[2] | ifb.rsp_q[3], 32'h0);
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_d = '0;
    ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_d = '0;
    for (int i = 0; i < 4; i++) begin gcnt[i] = 0; wt[i] = 0; end
    maxwt = 0;

    // Reset with all requesters active: everything must stay quiet.
    repeat (2) @(negedge clk);
    ifa.req_valid = 4'hF;
    for (int i = 0; i < 4; i++) ifa.req_addr[i] = 8'(10 + i);
    #1;
    check("rst_ready", 32'(ifa.req_ready), 32'h0);
    check("rst_mem_en", 32'(ifa.mem_en), 32'h0);
    check("rst_mem_addr", 32'(ifa.mem_addr), 32'h0);
    check("rst_mem_d", ifa.mem_d[0] | ifa.mem_d[1], 32'h0);
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    check("rst_rr_ptr", 32'(dut_a.rr_ptr), 32'h0);

    // Release: no grant before the first edge.
    @(negedge clk); rst_n_a = 1'b1; #1;
    check("release_idle", 32'(ifa.req_ready), 32'h0);

    // Four reads of 10..13, two per cycle.
    @(negedge clk); #1;
    check("rd_c1_ready", 32'(ifa.req_ready), 32'h3);
    check("rd_c1_addr0", 32'(ifa.mem_addr[0]), 32'd10);
    check("rd_c1_addr1", 32'(ifa.mem_addr[1]), 32'd11);
    check("rd_c1_en", 32'(ifa.mem_en), 32'h0);
    @(negedge clk); ifa.req_valid = 4'b1100; #1;
    check("rd_c2_ready", 32'(ifa.req_ready), 32'hC);
    check("rd_c2_addr0", 32'(ifa.mem_addr[0]), 32'd12);
    check("rd_c2_addr1", 32'(ifa.mem_addr[1]), 32'd13);
    check("rd_c2_rsp_valid", 32'(ifa.rsp_valid), 32'h3);
    check("rd_c2_rsp0", ifa.rsp_q[0], 32'h100A);
    check("rd_c2_rsp1", ifa.rsp_q[1], 32'h100B);
    check("rd_c2_rsp2_zero", ifa.rsp_q[2], 32'h0);
    @(negedge clk); ifa.req_valid = 4'b0000; #1;
    check("rd_c3_ready", 32'(ifa.req_ready), 32'h0);
    check("rd_c3_rr_ptr", 32'(dut_a.rr_ptr), 32'h0);
    check("rd_c3_rsp_valid", 32'(ifa.rsp_valid), 32'hC);
    check("rd_c3_rsp2", ifa.rsp_q[2], 32'h100C);
    check("rd_c3_rsp3", ifa.rsp_q[3], 32'h100D);
    check("rd_c3_rsp0_zero", ifa.rsp_q[0], 32'h0);

    // Write/write hazard on address 5.
    @(negedge clk);
    ifa.req_valid = 4'b0110; ifa.req_we = 4'b0110;
    ifa.req_addr[1] = 8'd5; ifa.req_addr[2] = 8'd5;
    ifa.req_d[1] = 32'hA; ifa.req_d[2] = 32'hB;
    #1;
    check("ww_c1_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    check("ww_c1_ready", 32'(ifa.req_ready), 32'h2);
    check("ww_c1_en", 32'(ifa.mem_en), 32'h1);
    check("ww_c1_addr0", 32'(ifa.mem_addr[0]), 32'd5);
    check("ww_c1_d0", ifa.mem_d[0], 32'hA);
    check("ww_c1_addr1_idle", 32'(ifa.mem_addr[1]), 32'h0);
    check("ww_c1_d1_idle", ifa.mem_d[1], 32'h0);
    @(negedge clk); ifa.req_valid = 4'b0100; #1;
    check("ww_c2_ready", 32'(ifa.req_ready), 32'h4);
    check("ww_c2_en", 32'(ifa.mem_en), 32'h1);
    check("ww_c2_d0", ifa.mem_d[0], 32'hB);
    @(negedge clk);
    ifa.req_valid = 4'b0001; ifa.req_we = 4'b0000; ifa.req_addr[0] = 8'd5;
    #1;
    check("ww_rd_ready", 32'(ifa.req_ready), 32'h1);
    check("ww_rd_en", 32'(ifa.mem_en), 32'h0);
    // Requester 3 reads 20 to bring rr_ptr back to 0.
    @(negedge clk); ifa.req_valid = 4'b1000; ifa.req_addr[3] = 8'd20; #1;
    check("ww_rsp_valid", 32'(ifa.rsp_valid), 32'h1);
    check("ww_rsp0", ifa.rsp_q[0], 32'hB);
    check("r3_ready", 32'(ifa.req_ready), 32'h8);

    // Read of 7 against write of 7 in the same cycle.
    @(negedge clk);
    ifa.req_valid = 4'b0011; ifa.req_we = 4'b0010;
    ifa.req_addr[0] = 8'd7; ifa.req_addr[1] = 8'd7; ifa.req_d[1] = 32'h77;
    #1;
    check("r3_rsp_valid", 32'(ifa.rsp_valid), 32'h8);
    check("r3_rsp3", ifa.rsp_q[3], 32'h1014);
    check("rw_c1_ready", 32'(ifa.req_ready), 32'h1);
    check("rw_c1_en", 32'(ifa.mem_en), 32'h0);
    check("rw_c1_addr0", 32'(ifa.mem_addr[0]), 32'd7);
    check("rw_c1_addr1_idle", 32'(ifa.mem_addr[1]), 32'h0);
    @(negedge clk); ifa.req_valid = 4'b0010; #1;
    check("rw_c2_ready", 32'(ifa.req_ready), 32'h2);
    check("rw_c2_en", 32'(ifa.mem_en), 32'h1);
    check("rw_c2_d0", ifa.mem_d[0], 32'h77);
    check("rw_c2_rsp_valid", 32'(ifa.rsp_valid), 32'h1);
    check("rw_c2_rsp0", ifa.rsp_q[0], 32'h1007);

    // Back-to-back reads of 1,2,3 from requester 2.
    @(negedge clk);
    ifa.req_valid = 4'b0100; ifa.req_we = 4'b0000; ifa.req_addr[2] = 8'd1;
    #1;
    check("b2b_c1_ready", 32'(ifa.req_ready), 32'h4);
    check("b2b_c1_addr0", 32'(ifa.mem_addr[0]), 32'd1);
    check("b2b_c1_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    @(negedge clk); ifa.req_addr[2] = 8'd2; #1;
    check("b2b_c2_ready", 32'(ifa.req_ready), 32'h4);
    check("b2b_c2_rsp_valid", 32'(ifa.rsp_valid), 32'h4);
    check("b2b_c2_rsp2", ifa.rsp_q[2], 32'h1001);
    @(negedge clk); ifa.req_addr[2] = 8'd3; #1;
    check("b2b_c3_ready", 32'(ifa.req_ready), 32'h4);
    check("b2b_c3_rsp2", ifa.rsp_q[2], 32'h1002);
    @(negedge clk); ifa.req_valid = 4'b0000; #1;
    check("b2b_c4_rsp_valid", 32'(ifa.rsp_valid), 32'h4);
    check("b2b_c4_rsp2", ifa.rsp_q[2], 32'h1003);

    // Fairness: all four continuously valid with distinct addresses.
    @(negedge clk);
    ifa.req_valid = 4'hF;
    for (int i = 0; i < 4; i++) ifa.req_addr[i] = 8'(40 + i);
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ifa.req_ready[i]) begin
          gcnt[i]++;
          wt[i] = 0;
        end else begin
          wt[i]++;
          if (wt[i] > maxwt) maxwt = wt[i];
        end
      end
      @(negedge clk);
    end
    ifa.req_valid = 4'h0;
    check("fair_grants0", 32'(gcnt[0]), 32'd10);
    check("fair_grants1", 32'(gcnt[1]), 32'd10);
    check("fair_grants2", 32'(gcnt[2]), 32'd10);
    check("fair_grants3", 32'(gcnt[3]), 32'd10);
    check("fair_max_wait_le2", 32'(maxwt <= 2), 32'd1);

    // Instance B (READ_LATENCY=3): a normal read first.
    rst_n_b = 1'b1;
    @(negedge clk); ifb.req_valid = 4'b0001; ifb.req_addr[0] = 8'd3; #1;
    check("b_rd_ready", 32'(ifb.req_ready), 32'h1);
    @(negedge clk); ifb.req_valid = 4'b0000; #1;
    check("b_rd_lat1", 32'(ifb.rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("b_rd_lat2", 32'(ifb.rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("b_rd_lat3_valid", 32'(ifb.rsp_valid), 32'h1);
    check("b_rd_lat3_q", ifb.rsp_q[0], 32'h1003);

    // Second read, then reset in the following cycle.
    @(negedge clk); ifb.req_valid = 4'b0001; ifb.req_addr[0] = 8'd9; #1;
    check("b_rd2_ready", 32'(ifb.req_ready), 32'h1);
    @(negedge clk);
    rst_n_b = 1'b0;
    ifb.req_valid = 4'hF;
    #1;
    check_b_quiet("b_rst0");
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      check_b_quiet("b_rst");
    end
    @(negedge clk); ifb.req_valid = 4'h0; rst_n_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("b_after_rst_rsp_valid", 32'(ifb.rsp_valid), 32'h0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
